// File: rtl/core7_mem_copy_master.sv
// Word-by-word memory copy master: one read, one latency cycle, one write per word.
// Optional running checksum of copied words when CORE7_MEMCOPY_CHECKSUM_EN is defined.
module core7_mem_copy_master #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W:0]     length,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic [DATA_W-1:0]   m_writedata,
  input  logic [DATA_W-1:0]   m_readdata
`ifdef CORE7_MEMCOPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]   checksum
`endif
);

  localparam int BE_W = DATA_W / 8;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] LAT  = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] FIN  = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] src_r;
  logic [ADDR_W-1:0] dst_r;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   idx_nxt;
  logic [DATA_W-1:0] data_r;

  assign idx_nxt     = idx + 1'b1;
  assign m_writedata = data_r;

  // Bus outputs are registered together with the state they belong to, so they
  // change on the same edge the FSM enters RD/LAT/WR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      m_address    <= '0;
      m_chipselect <= 1'b0;
      m_write      <= 1'b0;
      m_byteenable <= '0;
      src_r        <= '0;
      dst_r        <= '0;
      len_r        <= '0;
      idx          <= '0;
      data_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (length != '0) begin
              src_r        <= src_addr;
              dst_r        <= dst_addr;
              len_r        <= length;
              idx          <= '0;
              state        <= RD;
              m_chipselect <= 1'b1;
              m_write      <= 1'b0;
              m_address    <= src_addr;
              m_byteenable <= {BE_W{1'b1}};
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        RD: begin
          state        <= LAT;
          m_chipselect <= 1'b0;
          m_byteenable <= '0;
        end
        LAT: begin
          data_r       <= m_readdata;
          state        <= WR;
          m_chipselect <= 1'b1;
          m_write      <= 1'b1;
          m_address    <= dst_r + idx[ADDR_W-1:0];
          m_byteenable <= {BE_W{1'b1}};
        end
        WR: begin
          idx     <= idx_nxt;
          m_write <= 1'b0;
          if (idx_nxt < len_r) begin
            state        <= RD;
            m_chipselect <= 1'b1;
            m_address    <= src_r + idx_nxt[ADDR_W-1:0];
            m_byteenable <= {BE_W{1'b1}};
          end else begin
            state        <= FIN;
            done         <= 1'b1;
            m_chipselect <= 1'b0;
            m_byteenable <= '0;
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          done         <= 1'b0;
          m_chipselect <= 1'b0;
          m_write      <= 1'b0;
          m_byteenable <= '0;
        end
      endcase
    end
  end

`ifdef CORE7_MEMCOPY_CHECKSUM_EN
  // Cleared on any accepted start, including zero-length copies.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= '0;
    end else if (state == IDLE && start) begin
      checksum <= '0;
    end else if (state == LAT) begin
      checksum <= checksum + m_readdata;
    end
  end
`endif

endmodule

// File: tb/tb_core7_mem_copy_master.sv
// Directed bench for core7_mem_copy_master with a one-cycle-latency memory model.
module tb_core7_mem_copy_master;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] m_address;
  logic              m_chipselect;
  logic              m_write;
  logic [3:0]        m_byteenable;
  logic [DATA_W-1:0] m_writedata;
  logic [DATA_W-1:0] m_readdata;
`ifdef CORE7_MEMCOPY_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  int checks   = 0;
  int failures = 0;

  core7_mem_copy_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write(m_write),
    .m_byteenable(m_byteenable), .m_writedata(m_writedata), .m_readdata(m_readdata)
`ifdef CORE7_MEMCOPY_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // Memory model plus a backdoor write port used only while the DUT is idle.
  logic [DATA_W-1:0] mem [0:8191];
  logic              bd_we = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [DATA_W-1:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (m_chipselect && m_write) mem[m_address] <= m_writedata;
    if (m_chipselect && !m_write) m_readdata <= mem[m_address];
  end

  logic [ADDR_W-1:0] rd_log [0:255];
  int rd_n = 0;
  int cs_n = 0;
  int done_n = 0;

  always @(posedge clk) begin
    if (m_chipselect && !m_write) begin
      rd_log[rd_n[7:0]] <= m_address;
      rd_n <= rd_n + 1;
    end
    if (m_chipselect) cs_n <= cs_n + 1;
    if (done) done_n <= done_n + 1;
  end

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  // Returns at the negedge where the FSM has just left IDLE.
  task automatic kick(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                      input logic [ADDR_W:0] n);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    length   = n;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic test_reset;
    reset_n  = 1'b0;
    start    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length   = '0;
    #3;
    checks++;
    if ({busy, done, m_chipselect, m_write} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=0000", {busy, done, m_chipselect, m_write});
    end
    checks++;
    if (m_address !== '0 || m_byteenable !== 4'h0 || m_writedata !== '0) begin
      failures++;
      $display("FAIL reset_bus addr=%0d be=%h wdata=%h want all zero", m_address, m_byteenable, m_writedata);
    end
`ifdef CORE7_MEMCOPY_CHECKSUM_EN
    checks++;
    if (checksum !== '0) begin
      failures++;
      $display("FAIL reset_checksum got=%0d want=0", checksum);
    end
`endif
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic_copy;
    logic              exp_cs, exp_w, exp_done;
    logic [ADDR_W-1:0] exp_a;
    for (int i = 0; i < 4; i++) poke(ADDR_W'(i), DATA_W'(i + 1));
    for (int i = 0; i < 4; i++) poke(ADDR_W'(100 + i), 32'h0);
    kick(13'd0, 13'd100, 14'd4);
    for (int n = 0; n <= 12; n++) begin
      exp_done = (n == 12);
      exp_cs   = (n < 12) && (n % 3 != 1);
      exp_w    = (n < 12) && (n % 3 == 2);
      exp_a    = (n % 3 == 0) ? ADDR_W'(n / 3) : ADDR_W'(100 + n / 3);
      checks++;
      if (m_chipselect !== exp_cs || m_write !== exp_w || done !== exp_done || busy !== 1'b1) begin
        failures++;
        $display("FAIL basic_ctrl cyc=%0d cs/wr/done/busy got=%b%b%b%b want=%b%b%b1",
                 n, m_chipselect, m_write, done, busy, exp_cs, exp_w, exp_done);
      end
      checks++;
      if (m_byteenable !== (exp_cs ? 4'hF : 4'h0)) begin
        failures++;
        $display("FAIL basic_be cyc=%0d got=%h want=%h", n, m_byteenable, exp_cs ? 4'hF : 4'h0);
      end
      if (exp_cs) begin
        checks++;
        if (m_address !== exp_a) begin
          failures++;
          $display("FAIL basic_addr cyc=%0d got=%0d want=%0d", n, m_address, exp_a);
        end
      end
      if (exp_w) begin
        checks++;
        if (m_writedata !== DATA_W'(n / 3 + 1)) begin
          failures++;
          $display("FAIL basic_wdata cyc=%0d got=%0d want=%0d", n, m_writedata, n / 3 + 1);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle busy=%b done=%b want 0 0", busy, done);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[100 + i] !== DATA_W'(i + 1)) begin
        failures++;
        $display("FAIL basic_mem[%0d] got=%0d want=%0d", 100 + i, mem[100 + i], i + 1);
      end
    end
`ifdef CORE7_MEMCOPY_CHECKSUM_EN
    checks++;
    if (checksum !== 32'd10) begin
      failures++;
      $display("FAIL basic_checksum got=%0d want=10", checksum);
    end
`endif
  endtask

  task automatic test_zero_length;
    int cs0 = cs_n;
    int dn0 = done_n;
    kick(13'd5, 13'd50, 14'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL zero_done done=%b busy=%b want 1 1", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_idle done=%b busy=%b want 0 0", done, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (cs_n !== cs0 || done_n !== dn0 + 1) begin
      failures++;
      $display("FAIL zero_access cs_cycles=%0d dones=%0d want 0 1", cs_n - cs0, done_n - dn0);
    end
  endtask

  task automatic test_wrap;
    int r0;
    int k;
    logic [ADDR_W-1:0] exp_rd [0:2];
    exp_rd[0] = 13'd8190;
    exp_rd[1] = 13'd8191;
    exp_rd[2] = 13'd0;
    poke(13'd8190, 32'hA);
    poke(13'd8191, 32'hB);
    poke(13'd0, 32'hC);
    for (int i = 0; i < 3; i++) poke(ADDR_W'(200 + i), 32'h0);
    r0 = rd_n;
    kick(13'd8190, 13'd200, 14'd3);
    for (k = 0; k < 100 && done !== 1'b1; k++) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL wrap_timeout done=%b want 1", done);
    end
    @(negedge clk);
    checks++;
    if (rd_n - r0 !== 3) begin
      failures++;
      $display("FAIL wrap_read_count got=%0d want=3", rd_n - r0);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_log[8'(r0 + i)] !== exp_rd[i]) begin
        failures++;
        $display("FAIL wrap_read[%0d] got=%0d want=%0d", i, rd_log[8'(r0 + i)], exp_rd[i]);
      end
      checks++;
      if (mem[200 + i] !== DATA_W'(32'hA + i)) begin
        failures++;
        $display("FAIL wrap_mem[%0d] got=%h want=%h", 200 + i, mem[200 + i], 32'hA + i);
      end
    end
`ifdef CORE7_MEMCOPY_CHECKSUM_EN
    checks++;
    if (checksum !== 32'h21) begin
      failures++;
      $display("FAIL wrap_checksum got=%h want=21", checksum);
    end
`endif
  endtask

  task automatic test_start_ignored;
    int r0;
    int d0;
    int k;
    poke(13'd300, 32'h11);
    poke(13'd301, 32'h22);
    poke(13'd302, 32'h33);
    for (int i = 0; i < 3; i++) poke(ADDR_W'(400 + i), 32'h0);
    poke(13'd500, 32'hDEAD);
    r0 = rd_n;
    d0 = done_n;
    kick(13'd300, 13'd400, 14'd3);
    @(negedge clk);
    src_addr = 13'd0;
    dst_addr = 13'd500;
    length   = 14'd5;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    for (k = 0; k < 100 && done !== 1'b1; k++) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL ignore_timeout done=%b want 1", done);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rd_n - r0 !== 3 || done_n - d0 !== 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_counts reads=%0d dones=%0d busy=%b want 3 1 0", rd_n - r0, done_n - d0, busy);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_log[8'(r0 + i)] !== ADDR_W'(300 + i) || mem[400 + i] !== DATA_W'(32'h11 * (i + 1))) begin
        failures++;
        $display("FAIL ignore_word[%0d] rd=%0d mem=%h want rd=%0d mem=%h",
                 i, rd_log[8'(r0 + i)], mem[400 + i], 300 + i, 32'h11 * (i + 1));
      end
    end
    checks++;
    if (mem[500] !== 32'hDEAD) begin
      failures++;
      $display("FAIL ignore_dst_untouched got=%h want=dead", mem[500]);
    end
  endtask

  task automatic test_reset_midcopy;
    int d0;
    int k;
    for (int i = 0; i < 5; i++) poke(ADDR_W'(600 + i), DATA_W'(32'h60 + i));
    for (int i = 0; i < 5; i++) poke(ADDR_W'(700 + i), 32'h0);
    poke(13'd710, 32'h0);
    poke(13'd711, 32'h0);
    d0 = done_n;
    kick(13'd600, 13'd700, 14'd5);
    repeat (8) @(negedge clk);
    checks++;
    if (m_chipselect !== 1'b1 || m_write !== 1'b1 || m_address !== 13'd702) begin
      failures++;
      $display("FAIL midrst_wr2 cs=%b wr=%b addr=%0d want 1 1 702", m_chipselect, m_write, m_address);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, m_chipselect, m_write} !== 4'b0 || m_address !== '0 ||
        m_byteenable !== 4'h0 || m_writedata !== '0) begin
      failures++;
      $display("FAIL midrst_outputs busy=%b done=%b cs=%b wr=%b addr=%0d be=%h wd=%h want all 0",
               busy, done, m_chipselect, m_write, m_address, m_byteenable, m_writedata);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (done_n !== d0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_no_done dones=%0d busy=%b want 0 0", done_n - d0, busy);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem[700 + i] !== ((i < 2) ? DATA_W'(32'h60 + i) : 32'h0)) begin
        failures++;
        $display("FAIL midrst_mem[%0d] got=%h want=%h", 700 + i, mem[700 + i],
                 (i < 2) ? 32'h60 + i : 32'h0);
      end
    end
    kick(13'd603, 13'd710, 14'd2);
    for (k = 0; k < 100 && done !== 1'b1; k++) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL midrst_fresh_timeout done=%b want 1", done);
    end
    @(negedge clk);
    checks++;
    if (mem[710] !== 32'h63 || mem[711] !== 32'h64) begin
      failures++;
      $display("FAIL midrst_fresh_mem got=%h,%h want=63,64", mem[710], mem[711]);
    end
`ifdef CORE7_MEMCOPY_CHECKSUM_EN
    checks++;
    if (checksum !== 32'hC7) begin
      failures++;
      $display("FAIL midrst_checksum got=%h want=c7", checksum);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_zero_length();
    test_wrap();
    test_start_ignored();
    test_reset_midcopy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/core7_mem_copy_master.md
CORE7_MEM_COPY_MASTER -- requirements
Module: core7_mem_copy_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 13, word-address width of the attached memory port.
REQ-002 The block SHALL have parameter DATA_W, default 32, data width; the byte-enable width SHALL be DATA_W/8.
REQ-003 The block SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, one-cycle copy request.
REQ-006 The block SHALL have port src_addr, input, ADDR_W, first source word address, sampled with start.
REQ-007 The block SHALL have port dst_addr, input, ADDR_W, first destination word address, sampled with start.
REQ-008 The block SHALL have port length, input, ADDR_W+1, word count, sampled with start.
REQ-009 The block SHALL have port busy, output, 1, high while a copy is in progress.
REQ-010 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 The block SHALL have port m_address, output, ADDR_W, memory word address.
REQ-012 The block SHALL have port m_chipselect, output, 1, memory access strobe.
REQ-013 The block SHALL have port m_write, output, 1, write qualifier (0 = read).
REQ-014 The block SHALL have port m_byteenable, output, DATA_W/8, byte lanes.
REQ-015 The block SHALL have port m_writedata, output, DATA_W, write data.
REQ-016 The block SHALL have port m_readdata, input, DATA_W, memory read data, valid exactly one cycle after a read address is presented.

Function
REQ-017 The block SHALL use FSM states IDLE, RD, LAT, WR, FIN.
REQ-018 In IDLE, start with length != 0 SHALL latch src_addr, dst_addr, length, clear the word index, and enter RD next cycle.
REQ-019 In IDLE, start with length == 0 SHALL enter FIN directly with no memory access.
REQ-020 RD SHALL drive m_chipselect=1, m_write=0, m_address=src+index for exactly one cycle, then enter LAT.
REQ-021 LAT SHALL drive m_chipselect=0, capture m_readdata into a data register at the clock edge ending the cycle, then enter WR.
REQ-022 WR SHALL drive m_chipselect=1, m_write=1, m_address=dst+index, m_writedata=captured data for exactly one cycle, then increment index.
REQ-023 After WR, the block SHALL enter RD if the incremented index < length, else FIN; each word therefore costs exactly 3 cycles.
REQ-024 FIN SHALL assert done for one cycle and return to IDLE.
REQ-025 Address arithmetic SHALL be modulo 2^ADDR_W; e.g. src 8191 + 1 wraps to 0.
REQ-026 m_byteenable SHALL be all ones whenever m_chipselect=1, else zero.
REQ-027 busy SHALL be high in RD, LAT, WR and FIN, and low in IDLE.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 Overlapping source/destination ranges SHALL be copied strictly in ascending index order with no hazard handling.
REQ-030 m_chipselect, m_write SHALL be registered outputs; no combinational path from m_readdata to any output.

Reset
REQ-031 reset_n low SHALL asynchronously force state IDLE and zero busy, done, m_address, m_chipselect, m_write, m_byteenable, m_writedata, index and data register.
REQ-032 Reset mid-copy SHALL abort immediately with no further memory access and no done pulse; the next start after release SHALL behave as from power-up.

Configuration
REQ-033 With macro CORE7_MEMCOPY_CHECKSUM_EN defined, the block SHALL add output checksum, DATA_W, modulo-2^DATA_W sum of all words captured in LAT, cleared on accepted start, stable from done until the next accepted start, zero on reset.
REQ-034 Without CORE7_MEMCOPY_CHECKSUM_EN, the checksum port and its adder SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-035 Bench SHALL cover: memory[0..3]=1,2,3,4; start src=0 dst=100 len=4 -> memory[100..103]=1,2,3,4, done 12 cycles after RD entry, checksum=10 when enabled.
REQ-036 Bench SHALL cover: start len=0 -> done pulse next cycle, m_chipselect never asserted.
REQ-037 Bench SHALL cover: src=8190 len=3 -> reads at 8190, 8191, 0 in that order.
REQ-038 Bench SHALL cover: start pulsed during busy with different parameters -> ignored, original copy completes unaltered.
REQ-039 Bench SHALL cover: reset_n low during a WR cycle of word 2 of 5 -> all outputs 0 same cycle, no done, word 2 unwritten; fresh copy after release succeeds.
